// File: rtl/alarm_audio_scheduler.sv
// Shares the codec sample path between the alarm beep pattern and key-click feedback.
// Counters advance per accepted sample write; the click overrides the alarm only at the output mux.
module alarm_audio_scheduler #(
    parameter int TONE_HALF  = 24,
    parameter int CLICK_HALF = 12,
    parameter int BEEP_ON    = 24000,
    parameter int BEEP_OFF   = 24000,
    parameter int CLICK_LEN  = 1200,
    parameter int DATA_W     = 32,
    parameter logic signed [DATA_W-1:0] AMPLITUDE = 32'sd10000000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     alarm_on,
    input  logic                     click_req,
    input  logic                     audio_out_allowed,
    output logic                     write_audio_out,
    output logic signed [DATA_W-1:0] audio_data,
    output logic                     beeping,
    output logic                     click_busy
);

    localparam int PAT_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PAT_W   = (PAT_MAX > 1)    ? $clog2(PAT_MAX)    : 1;
    localparam int TONE_W  = (TONE_HALF > 1)  ? $clog2(TONE_HALF)  : 1;
    localparam int CLK_W   = (CLICK_LEN > 1)  ? $clog2(CLICK_LEN)  : 1;
    localparam int CTONE_W = (CLICK_HALF > 1) ? $clog2(CLICK_HALF) : 1;

    localparam logic [PAT_W-1:0]   ON_LAST    = PAT_W'(BEEP_ON - 1);
    localparam logic [PAT_W-1:0]   OFF_LAST   = PAT_W'(BEEP_OFF - 1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);
    localparam logic [CLK_W-1:0]   CLICK_LAST = CLK_W'(CLICK_LEN - 1);
    localparam logic [CTONE_W-1:0] CHALF_LAST = CTONE_W'(CLICK_HALF - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat_cnt;
    logic [TONE_W-1:0]  tone_cnt;
    logic               tone_neg;
    logic [CLK_W-1:0]   click_cnt;
    logic [CTONE_W-1:0] click_tcnt;
    logic               click_neg;
    logic               wr;

    function automatic logic signed [DATA_W-1:0] square_sample(input logic neg);
        return neg ? -AMPLITUDE : AMPLITUDE;
    endfunction

    // Silence is still written when idle so the codec FIFO never starves.
    assign write_audio_out = audio_out_allowed & ~reset;
    assign wr              = write_audio_out;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            beeping  <= 1'b0;
            pat_cnt  <= '0;
            tone_cnt <= '0;
            tone_neg <= 1'b0;
        end else if (!alarm_on) begin
            state   <= IDLE;
            beeping <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= ON;
                    beeping  <= 1'b1;
                    pat_cnt  <= '0;
                    tone_cnt <= '0;
                    tone_neg <= 1'b0;
                end
                ON: if (wr) begin
                    if (pat_cnt == ON_LAST) begin
                        state   <= OFF;
                        pat_cnt <= '0;
                    end else begin
                        pat_cnt <= pat_cnt + 1'b1;
                    end
                    if (tone_cnt == TONE_LAST) begin
                        tone_neg <= ~tone_neg;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
                end
                OFF: if (wr) begin
                    if (pat_cnt == OFF_LAST) begin
                        state    <= ON;
                        pat_cnt  <= '0;
                        tone_cnt <= '0;
                        tone_neg <= 1'b0;
                    end else begin
                        pat_cnt <= pat_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    beeping <= 1'b0;
                end
            endcase
        end
    end

    // A new request always restarts the click, even on its final write.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            click_busy <= 1'b0;
            click_cnt  <= '0;
            click_tcnt <= '0;
            click_neg  <= 1'b0;
        end else if (click_req) begin
            click_busy <= 1'b1;
            click_cnt  <= '0;
            click_tcnt <= '0;
            click_neg  <= 1'b0;
        end else if (click_busy && wr) begin
            if (click_cnt == CLICK_LAST) begin
                click_busy <= 1'b0;
                click_cnt  <= '0;
            end else begin
                click_cnt <= click_cnt + 1'b1;
            end
            if (click_tcnt == CHALF_LAST) begin
                click_neg  <= ~click_neg;
                click_tcnt <= '0;
            end else begin
                click_tcnt <= click_tcnt + 1'b1;
            end
        end
    end

    always_comb begin
        audio_data = '0;
        if (click_busy) begin
            audio_data = square_sample(click_neg);
        end else if (state == ON) begin
            audio_data = square_sample(tone_neg);
        end
    end

endmodule

// File: tb/tb_alarm_audio_scheduler.sv
// Table-driven bench for alarm_audio_scheduler: per-cycle vectors plus a written-sample scoreboard.
module tb_alarm_audio_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               alarm;
    logic               click;
    logic               allowed;
    logic               write_audio_out;
    logic signed [31:0] audio_data;
    logic               beeping;
    logic               click_busy;

    alarm_audio_scheduler #(
        .TONE_HALF (2),
        .CLICK_HALF(1),
        .BEEP_ON   (8),
        .BEEP_OFF  (4),
        .CLICK_LEN (3),
        .DATA_W    (32),
        .AMPLITUDE (32'sd100)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (rst),
        .alarm_on         (alarm),
        .click_req        (click),
        .audio_out_allowed(allowed),
        .write_audio_out  (write_audio_out),
        .audio_data       (audio_data),
        .beeping          (beeping),
        .click_busy       (click_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit a;
        bit c;
        bit w;
        bit r;
        bit chk;
        int data;
        bit busy;
        bit beep;
    } vec_t;

    vec_t vecs[$];
    int   sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   running = 1'b0;
    int   mon_exp;
    int   beep_seq[12] = '{100, 100, -100, -100, 100, 100, -100, -100, 0, 0, 0, 0};

    task automatic add(input bit a, input bit c, input bit w, input bit r, input bit chk,
                       input int data, input bit busy, input bit beep);
        vec_t v;
        v = '{a, c, w, r, chk, data, busy, beep};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int cyc, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Scoreboard: every accepted write must carry the next queued sample.
    always @(negedge clk) begin
        if (running && write_audio_out === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_write", -1, 1, 0);
            end else begin
                mon_exp = sbq.pop_front();
                check("written_sample", -1, audio_data, mon_exp);
            end
        end
    end

    initial begin
        int idx;
        bit w;

        rst = 1'b1; alarm = 1'b0; click = 1'b0; allowed = 1'b0;

        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);

        // Beep pattern with continuous writes, then alarm drop mid-ON
        add(1, 0, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 26; k++) add(1, 0, 1, 0, 1, beep_seq[k % 12], 0, 1);
        add(0, 0, 1, 0, 1, beep_seq[26 % 12], 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Backpressure: same written sequence, data holds across gaps
        idx = 0;
        w = 1'($urandom_range(0, 1));
        add(1, 0, w, 0, 1, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            add(1, 0, w, 0, 1, beep_seq[idx % 12], 0, 1);
            if (w) idx++;
        end
        add(0, 0, 1, 0, 1, beep_seq[idx % 12], 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Click only, with one stalled cycle
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 0, 0, 1, -100, 1, 0);
        add(0, 0, 1, 0, 1, -100, 1, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Click preempts alarm at sample 3; cadence and OFF timing preserved
        add(1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 100, 0, 1);
        add(1, 0, 1, 0, 1, 100, 0, 1);
        add(1, 1, 1, 0, 1, -100, 0, 1);
        add(1, 0, 1, 0, 1, 100, 1, 1);
        add(1, 0, 1, 0, 1, -100, 1, 1);
        add(1, 0, 1, 0, 1, 100, 1, 1);
        add(1, 0, 1, 0, 1, -100, 0, 1);
        add(1, 0, 1, 0, 1, -100, 0, 1);
        for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 1, 100, 0, 1);
        add(0, 0, 1, 0, 1, 100, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Click retrigger mid-click
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 1, 1, 0, 1, -100, 1, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, -100, 1, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Retrigger on the final click write: restart wins
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, -100, 1, 0);
        add(0, 1, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, -100, 1, 0);
        add(0, 0, 1, 0, 1, 100, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Reset during ON with click active, alarm held high
        add(1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 100, 0, 1);
        add(1, 1, 1, 0, 1, 100, 0, 1);
        add(1, 0, 1, 0, 1, 100, 1, 1);
        add(1, 0, 1, 1, 1, -100, 1, 1);
        add(1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 100, 0, 1);
        add(1, 0, 1, 0, 1, 100, 0, 1);
        add(1, 0, 1, 0, 1, -100, 0, 1);
        add(1, 0, 1, 0, 1, -100, 0, 1);
        add(0, 0, 1, 0, 1, 100, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        // Click request coinciding with reset is dropped
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);

        running = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #2;
            alarm   = vecs[i].a;
            click   = vecs[i].c;
            allowed = vecs[i].w;
            rst     = vecs[i].r;
            if (vecs[i].w && !vecs[i].r) sbq.push_back(vecs[i].data);
            @(negedge clk);
            check("write_strobe", i, int'(write_audio_out), int'(vecs[i].w & ~vecs[i].r));
            if (vecs[i].chk) begin
                check("audio_data", i, audio_data, vecs[i].data);
                check("click_busy", i, int'(click_busy), int'(vecs[i].busy));
                check("beeping", i, int'(beeping), int'(vecs[i].beep));
            end
        end

        @(posedge clk);
        #2;
        allowed = 1'b0;
        click   = 1'b0;
        @(negedge clk);
        running = 1'b0;
        check("scoreboard_drained", vecs.size(), sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
